// File: rtl/fir_mac_filter.sv
// fir_mac_filter: sequential single-multiplier FIR filter.
// Each accepted sample goes through an NTAPS-deep delay line and is filtered
// with coefficients read from an external synchronous ROM, one tap per cycle.
// The result is rounded half toward +inf, shifted by OUT_SHIFT and saturated
// to DATA_W bits.
//
// Ports:
//   i_clock          rising-edge clock
//   i_reset_n        asynchronous active-low reset
//   i_datain         input sample (signed)
//   i_endata         input sample valid
//   o_indata_ready   high in IDLE, when a sample can be accepted
//   i_flush          synchronous clear of delay line / accumulator, aborts a run
//   o_dataout        filtered sample (signed), held until the next result
//   o_dataout_valid  one-cycle pulse when o_dataout updates
//   o_overrun        high in any cycle where i_endata is dropped because busy
//   o_coefaddress    registered coefficient ROM address
//   i_coefdata       ROM data, valid one cycle after o_coefaddress changes
//
// state  | meaning
// IDLE   | waiting for a sample, o_indata_ready high
// MAC    | stepping the ROM address, accumulating taps 0..NTAPS-2
// DONE   | final tap folded straight into round/saturate, result registered

module fir_mac_filter #(
  parameter int DATA_W    = 18,
  parameter int COEF_W    = 18,
  parameter int NTAPS     = 65,
  parameter int OUT_SHIFT = 17
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic [DATA_W-1:0]        i_datain,
  input  logic                     i_endata,
  output logic                     o_indata_ready,
  input  logic                     i_flush,
  output logic [DATA_W-1:0]        o_dataout,
  output logic                     o_dataout_valid,
  output logic                     o_overrun,
  output logic [$clog2(NTAPS)-1:0] o_coefaddress,
  input  logic [COEF_W-1:0]        i_coefdata
);

  localparam int AW     = $clog2(NTAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(NTAPS);
  localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

  localparam logic [AW-1:0]        LAST_TAP = AW'(NTAPS - 1);
  localparam logic signed [ACC_W:0] RND    = (OUT_SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;
  localparam logic signed [ACC_W:0] MAX_V  = {{(ACC_W+1-DATA_W){1'b0}}, 1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_V  = {{(ACC_W+1-DATA_W){1'b1}}, 1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_accept;

  logic signed [DATA_W-1:0]  r_x [NTAPS];
  logic signed [ACC_W-1:0]   r_acc;
  logic [AW-1:0]             r_addr;
  logic [AW-1:0]             r_tap;     // address issued last cycle = tap whose data is on i_coefdata
  logic                      r_first;   // first MAC cycle: ROM data not yet valid
  logic [DATA_W-1:0]         r_dataout;
  logic                      r_dataout_valid;

  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_sum;
  logic signed [ACC_W:0]     w_rnd;
  logic signed [ACC_W:0]     w_shr;
  logic [DATA_W-1:0]         w_out;

  assign w_prod = r_x[r_tap] * $signed(i_coefdata);
  assign w_sum  = r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  // One guard bit so the rounding offset can never wrap the sum.
  assign w_rnd  = {w_sum[ACC_W-1], w_sum} + RND;
  assign w_shr  = w_rnd >>> OUT_SHIFT;

  always_comb begin
    w_out = w_shr[DATA_W-1:0];
    if (w_shr > MAX_V) begin
      w_out = MAX_V[DATA_W-1:0];
    end else if (w_shr < MIN_V) begin
      w_out = MIN_V[DATA_W-1:0];
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_endata) begin
          w_state_nxt = S_MAC;
          w_accept    = 1'b1;
        end
      end
      S_MAC: begin
        if (r_addr == LAST_TAP) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_flush) begin
      w_state_nxt = S_IDLE;
      w_accept    = 1'b0;
    end
  end

  // The last tap is not written back before rounding: DONE rounds
  // acc + x[NTAPS-1]*h[NTAPS-1] directly, which saves a cycle so the result
  // and the next accept window land NTAPS+2 cycles after each accept.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < NTAPS; k++) begin
        r_x[k] <= '0;
      end
      r_acc           <= '0;
      r_addr          <= '0;
      r_tap           <= '0;
      r_first         <= 1'b0;
      r_dataout       <= '0;
      r_dataout_valid <= 1'b0;
    end else begin
      r_dataout_valid <= 1'b0;
      if (i_flush) begin
        for (int k = 0; k < NTAPS; k++) begin
          r_x[k] <= '0;
        end
        r_acc   <= '0;
        r_addr  <= '0;
        r_tap   <= '0;
        r_first <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_x[0] <= $signed(i_datain);
              for (int k = 1; k < NTAPS; k++) begin
                r_x[k] <= r_x[k-1];
              end
              r_acc   <= '0;
              r_addr  <= '0;
              r_tap   <= '0;
              r_first <= 1'b1;
            end
          end
          S_MAC: begin
            if (r_addr != LAST_TAP) begin
              r_addr <= r_addr + 1'b1;
            end
            r_tap   <= r_addr;
            r_first <= 1'b0;
            if (!r_first) begin
              r_acc <= w_sum;
            end
          end
          S_DONE: begin
            r_acc           <= w_sum;
            r_dataout       <= w_out;
            r_dataout_valid <= 1'b1;
          end
          default: begin
            r_first <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_indata_ready  = (r_state == S_IDLE);
  assign o_overrun       = i_endata && !i_flush && (r_state != S_IDLE);
  assign o_coefaddress   = r_addr;
  assign o_dataout       = r_dataout;
  assign o_dataout_valid = r_dataout_valid;

endmodule
